// File: rtl/dmem_arbiter.sv
// Two-master arbiter (CPU load/store, aux loader/debug) for dmem port A.
// Optional macro DMEM_ARB_CPU_PRIO_EN: fixed CPU tie priority with aux aging.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU single-beat request
//   cpu_gnt, cpu_rvalid           CPU grant pulse, read-data-valid pulse
//   aux_req/we/addr/wdata         aux single-beat request
//   aux_gnt, aux_rvalid           aux grant pulse, read-data-valid pulse
//   rdata                         registered read data, shared
//   mem_addr/wdata/we, mem_rdata  dmem port A (combinational read)
//   busy                          high while a grant is in progress
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G_CPU = 2'd1,
    G_AUX = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_rv_q, cpu_rv_d;
  logic              aux_rv_q, aux_rv_d;
  logic              cpu_el, aux_el;
  logic              pick_aux;

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam int CW = $clog2(MAX_WAIT + 2);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  // Aux ages while it waits; once starved long enough it wins ties.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == G_AUX)
      wait_cnt_d = '0;
    else if (aux_req && wait_cnt_q < CW'(MAX_WAIT))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign pick_aux = (wait_cnt_q >= CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  // last_q = 1 when aux was served most recently.
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == G_CPU) last_d = 1'b0;
    if (state_q == G_AUX) last_d = 1'b1;
  end

  assign pick_aux = ~last_q;

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  // The master owning the current grant is masked out of the decision.
  assign cpu_el = cpu_req & (state_q != G_CPU);
  assign aux_el = aux_req & (state_q != G_AUX);

  always_comb begin
    state_d = IDLE;
    case ({cpu_el, aux_el})
      2'b11:   state_d = pick_aux ? G_AUX : G_CPU;
      2'b10:   state_d = G_CPU;
      2'b01:   state_d = G_AUX;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_gnt   = 1'b0;
    aux_gnt   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      G_CPU: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & ~reset;
      end
      G_AUX: begin
        aux_gnt   = 1'b1;
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        mem_we    = aux_we & ~reset;
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_rv_d = (state_q == G_CPU) & ~cpu_we;
    aux_rv_d = (state_q == G_AUX) & ~aux_we;
    rdata_d  = rdata_q;
    if (cpu_rv_d | aux_rv_d) rdata_d = mem_rdata;
  end

  // Reset wins over capture, so an aborted read yields no rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      cpu_rv_q <= 1'b0;
      aux_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      cpu_rv_q <= cpu_rv_d;
      aux_rv_q <= aux_rv_d;
    end
  end

  assign rdata      = rdata_q;
  assign cpu_rvalid = cpu_rv_q;
  assign aux_rvalid = aux_rv_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dmem.
// Ports: none (top-level testbench).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;
  logic        init;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .aux_req(aux_req), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
    .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8] <= 32'h1234_5678;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, busy, mem_we};
  endfunction

  initial begin
    reset = 1'b1; init = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
    tick;
    tick;
    init = 1'b0;
    chk("rst_flags", 64'(flags()), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_addr", 64'(mem_addr), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_flags", 64'(flags()), 64'h0);
      chk("idle_bus", {mem_addr, mem_wdata}, 64'h0);
    end

    // CPU write 0x10
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    tick;
    chk("wr_flags", 64'(flags()), 64'b100011);
    chk("wr_addr", 64'(mem_addr), 64'h10);
    chk("wr_data", 64'(mem_wdata), 64'hDEAD_BEEF);
    cpu_req = 0;
    tick;
    chk("wr_done", 64'(flags()), 64'h0);
    chk("wr_mem", 64'(mem[4]), 64'hDEAD_BEEF);

    // CPU read 0x10
    cpu_req = 1; cpu_we = 0;
    tick;
    chk("rd_gnt", 64'(flags()), 64'b100010);
    cpu_req = 0;
    tick;
    chk("rd_rv", 64'(flags()), 64'b001000);
    chk("rd_data", 64'(rdata), 64'hDEAD_BEEF);
    tick;
    chk("rd_rv_end", 64'(flags()), 64'h0);
    chk("rd_hold", 64'(rdata), 64'hDEAD_BEEF);

    // Aux read 0x20
    aux_req = 1; aux_we = 0; aux_addr = 32'h20;
    tick;
    chk("aux_gnt", 64'(flags()), 64'b010010);
    chk("aux_addr", 64'(mem_addr), 64'h20);
    aux_req = 0;
    tick;
    chk("aux_rv", 64'(flags()), 64'b000100);
    chk("aux_data", 64'(rdata), 64'h1234_5678);

    // Reset during a CPU write to 0x30
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h30; cpu_wdata = 32'hAAAA_5555;
    tick;
    chk("rw_gnt", 64'(cpu_gnt), 64'h1);
    reset = 1;
    #1;
    chk("rw_we0", 64'(mem_we), 64'h0);
    cpu_req = 0;
    tick;
    chk("rw_mem", 64'(mem[12]), 64'h0);
    chk("rw_idle", 64'(flags()), 64'h0);
    reset = 0;

    // Reset during an aux read: no rvalid
    aux_req = 1; aux_addr = 32'h20;
    tick;
    chk("rr_gnt", 64'(aux_gnt), 64'h1);
    reset = 1; aux_req = 0;
    tick;
    chk("rr_norv", 64'(flags()), 64'h0);
    chk("rr_rdata", 64'(rdata), 64'h0);

    // Request in the cycle reset deasserts
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    tick;
    chk("rel_gnt", 64'(flags()), 64'b100010);
    cpu_req = 0;
    tick;
    chk("rel_data", 64'(rdata), 64'hDEAD_BEEF);

    // Both requesting continuously from reset: alternate
    reset = 1;
    tick;
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    aux_req = 1; aux_we = 0; aux_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("alt_gnt", 64'({cpu_gnt, aux_gnt}),
          (i % 2 == 0) ? 64'b10 : 64'b01);
      chk("alt_rv2", 64'(cpu_rvalid & aux_rvalid), 64'h0);
    end
    cpu_req = 0; aux_req = 0;
    tick;
    tick;
    chk("alt_idle", 64'(busy), 64'h0);

`ifdef DMEM_ARB_CPU_PRIO_EN
    begin
      int waited;
      bit got;
      waited = 0;
      got = 0;
      reset = 1;
      tick;
      reset = 0;
      cpu_req = 1; aux_req = 1;
      for (int i = 0; i < 8 && !got; i++) begin
        tick;
        if (aux_gnt) got = 1;
        else waited++;
      end
      chk("prio_got", 64'(got), 64'h1);
      chk("prio_wait_le4", 64'(waited <= 4), 64'h1);
      tick;
      chk("prio_cnt0", 64'(dut.wait_cnt_q), 64'h0);
      cpu_req = 0; aux_req = 0;
      tick;
      tick;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
